ram_request_encoder: RTL and testbench



---
 rtl/ram_ctrl_pkg.sv | 17 +
 rtl/rr_pick.sv | 31 +++
 rtl/ram_request_encoder.sv | 133 +++++++++++++
 tb/tb_ram_request_encoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM request path.
// Holds the arbiter state enum, ADDR_W helper and timeout default.
package ram_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int TIMEOUT_CYCLES_DEF = 15;

  // Address width for n words; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr.
// Ports: req, ptr in; found, winner out. Search wraps modulo N.
module rr_pick
  import ram_ctrl_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = addr_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] winner
);

  logic [W-1:0] idx;

  // N is a power of two, so wrapping is plain W-bit overflow.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ram_request_encoder.sv
// Round-robin initiator: encodes client word requests into address/memory_en.
// Ports: clk, rst, req, mem_ready in; address, memory_en, grant, done,
// timeout_err out. Define RAM_REQ_TIMEOUT_EN to enable the BUSY watchdog.
module ram_request_encoder
  import ram_ctrl_pkg::*;
#(
  parameter  int NUM_WORDS      = 4,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int ADDR_W         = addr_w(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WORDS-1:0] req,
  input  logic                 mem_ready,
  output logic [ADDR_W-1:0]    address,
  output logic                 memory_en,
  output logic [NUM_WORDS-1:0] grant,
  output logic                 done,
  output logic                 timeout_err
);

  if (NUM_WORDS < 2 ||
      (NUM_WORDS & (NUM_WORDS - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ram_request_encoder: bad parameters");
  end

  state_t                state;
  logic [ADDR_W-1:0]     ptr;
  logic                  found;
  logic [ADDR_W-1:0]     winner;
  logic [NUM_WORDS-1:0]  win_oh;

  rr_pick #(
    .N(NUM_WORDS)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .winner(winner)
  );

  always_comb begin
    win_oh         = '0;
    win_oh[winner] = 1'b1;
  end

`ifdef RAM_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      address     <= '0;
      memory_en   <= 1'b0;
      grant       <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      timer       <= '0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state     <= BUSY;
            address   <= winner;
            memory_en <= 1'b1;
            grant     <= win_oh;
            ptr       <= winner + 1'b1;
            timer     <= '0;
          end
        end
        BUSY: begin
          // mem_ready beats a coincident timeout.
          if (mem_ready) begin
            state     <= IDLE;
            memory_en <= 1'b0;
            grant     <= '0;
            done      <= 1'b1;
          end else if (timer == T_LAST) begin
            state       <= IDLE;
            memory_en   <= 1'b0;
            grant       <= '0;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end
`else
  assign timeout_err = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      address   <= '0;
      memory_en <= 1'b0;
      grant     <= '0;
      done      <= 1'b0;
      ptr       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state     <= BUSY;
            address   <= winner;
            memory_en <= 1'b1;
            grant     <= win_oh;
            ptr       <= winner + 1'b1;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state     <= IDLE;
            memory_en <= 1'b0;
            grant     <= '0;
            done      <= 1'b1;
          end
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ram_request_encoder.sv
// Directed bench for ram_request_encoder with a grant scoreboard.
// Define RAM_REQ_TIMEOUT_EN to also exercise the BUSY watchdog.
module tb_ram_request_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mem_ready;
  logic [1:0] address;
  logic       memory_en;
  logic [3:0] grant;
  logic       done;
  logic       timeout_err;

  typedef struct packed {
    logic [1:0] a;
    logic [3:0] g;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   mptr   = 0;
  bit   inv_on = 1'b0;

  always #5 clk = ~clk;

  ram_request_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mem_ready  (mem_ready),
    .address    (address),
    .memory_en  (memory_en),
    .grant      (grant),
    .done       (done),
    .timeout_err(timeout_err)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  // Outputs: {address, memory_en, grant, done, timeout_err}
  function automatic logic [31:0] outs();
    return {23'd0, address, memory_en, grant, done, timeout_err};
  endfunction

  function automatic logic [31:0] idle_v(logic [1:0] a, logic d);
    return {23'd0, a, 1'b0, 4'b0000, d, 1'b0};
  endfunction

  // Grant/address consistency, sampled away from the active edge.
  always @(negedge clk) begin
    if (inv_on) begin
      if (memory_en) chk("inv_onehot", {28'd0, grant}, 32'(4'b0001 << address));
      else chk("inv_idle", {28'd0, grant}, 32'd0);
    end
  end

  // Drive r from IDLE; expect the grant on the next edge.
  task automatic start(logic [3:0] r);
    int   w;
    exp_t e;
    req = r;
    w   = pick(r, mptr);
    e.a = 2'(w);
    e.g = 4'(4'b0001 << w);
    sb.push_back(e);
    mptr = (w + 1) % 4;
    tick();
    if (memory_en !== 1'b1 || sb.size() == 0) begin
      chk("grant_appears", {31'd0, memory_en}, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sb_addr", {30'd0, address}, {30'd0, e.a});
      chk("sb_grant", {28'd0, grant}, {28'd0, e.g});
    end
  endtask

  // Full access: n BUSY cycles, mem_ready on the last one.
  task automatic access(logic [3:0] r, int n, bit drop);
    logic [1:0] a;
    start(r);
    a = address;
    if (drop) req = 4'b0000;
    for (int i = 1; i < n; i++) begin
      tick();
      chk("busy_hold", outs(), {23'd0, a, 1'b1, grant, 1'b0, 1'b0});
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("done_pulse", outs(), idle_v(a, 1'b1));
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    mem_ready = 1'b0;
    tick();
    tick();
    chk("reset_state", outs(), idle_v(2'd0, 1'b0));
    inv_on = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_noreq", outs(), idle_v(2'd0, 1'b0));
    end

    // Single word 2, three BUSY cycles, client drops req mid-access.
    access(4'b0100, 3, 1'b1);
    chk("word2_addr", {30'd0, address}, 32'd2);
    tick();
    chk("done_once", outs(), idle_v(2'd2, 1'b0));

    // mem_ready in IDLE is ignored.
    mem_ready = 1'b1;
    tick();
    tick();
    chk("ready_in_idle", outs(), idle_v(2'd2, 1'b0));
    mem_ready = 1'b0;

    // Rotation from a fresh pointer, back to back.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mptr = 0;
    for (int k = 0; k < 5; k++) begin
      access(4'b1111, 1, 1'b0);
      chk("rr_seq", {30'd0, address}, 32'(k % 4));
    end

    // After word 1, ptr=2: req 0011 wraps to word 0.
    access(4'b0010, 1, 1'b0);
    start(4'b0011);
    chk("wrap_word0", {28'd0, grant}, 32'b0001);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;

    // Reset during BUSY on word 3.
    start(4'b1000);
    chk("busy_w3", {30'd0, address}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mptr = 0;
    chk("reset_abort", outs(), idle_v(2'd0, 1'b0));
    tick();
    chk("no_done_post", {31'd0, done}, 32'd0);
    access(4'b1000, 2, 1'b0);
    access(4'b1001, 1, 1'b0);
    chk("ptr_restart", {30'd0, address}, 32'd0);
    req = 4'b0000;
    tick();

`ifdef RAM_REQ_TIMEOUT_EN
    // No mem_ready: abort after 15 BUSY cycles.
    start(4'b0010);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("to_wait", {30'd0, memory_en, timeout_err}, 32'b10);
    end
    tick();
    chk("to_fire", outs(), {23'd0, 2'd1, 1'b0, 4'b0, 1'b0, 1'b1});
    tick();
    chk("to_once", {31'd0, timeout_err}, 32'd0);
    // Pointer advanced past word 1.
    start(4'b0011);
    chk("to_ptr_adv", {30'd0, address}, 32'd0);
    for (int i = 1; i < 15; i++) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("ready_wins", {30'd0, done, timeout_err}, 32'b10);
    req = 4'b0000;
    tick();
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    inv_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
